// File: rtl/peak_detector.sv
// Pulse peak detector for one shaping-filter channel: threshold trigger, peak amplitude/time,
// time-over-threshold and a hold-off window before re-arming.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | armed, waiting for a sample above threshold
// S_ABOVE    | inside a pulse, tracking maximum and width
// S_WAIT_LOW | pulse hit MAX_WIDTH and was reported, waiting for it to fall
// S_HOLDOFF  | counting consecutive below-threshold samples before re-arm
module peak_detector #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int WIDTH_W   = 8,
  parameter int MAX_WIDTH = 255,
  parameter int HOLDOFF   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  input_data,
  input  logic [DATA_W-1:0]  threshold,
  output logic               peak_valid,
  output logic [DATA_W-1:0]  peak_amplitude,
  output logic [TS_W-1:0]    peak_time,
  output logic [WIDTH_W-1:0] peak_width,
  output logic               too_long,
  output logic               busy
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [WIDTH_W-1:0] MAXW      = WIDTH_W'(MAX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ABOVE,
    S_WAIT_LOW,
    S_HOLDOFF
  } state_t;

  state_t state;

  logic [TS_W-1:0]          ts_cnt;
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] thr_r;
  logic [TS_W-1:0]          ts_r;

  logic signed [DATA_W-1:0] max_r;
  logic [TS_W-1:0]          tmax_r;
  logic [WIDTH_W-1:0]       width_r;
  logic [HW-1:0]            hold_cnt;

  logic                     above;
  logic                     new_peak;
  logic signed [DATA_W-1:0] max_next;
  logic [TS_W-1:0]          tmax_next;
  logic [WIDTH_W-1:0]       width_inc;

  always_comb begin
    above     = x_r > thr_r;
    new_peak  = x_r > max_r;
    max_next  = new_peak ? x_r : max_r;
    tmax_next = new_peak ? ts_r : tmax_r;
    width_inc = width_r + WIDTH_W'(1);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      ts_cnt         <= '0;
      x_r            <= '0;
      thr_r          <= '0;
      ts_r           <= '0;
      max_r          <= '0;
      tmax_r         <= '0;
      width_r        <= '0;
      hold_cnt       <= '0;
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_width     <= '0;
      too_long       <= 1'b0;
    end else begin
      // stage 1: capture sample, threshold and its timestamp together
      ts_cnt     <= ts_cnt + TS_W'(1);
      x_r        <= input_data;
      thr_r      <= threshold;
      ts_r       <= ts_cnt;
      peak_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (above) begin
            max_r   <= x_r;
            tmax_r  <= ts_r;
            width_r <= WIDTH_W'(1);
            if (MAX_WIDTH == 1) begin
              peak_valid     <= 1'b1;
              peak_amplitude <= x_r;
              peak_time      <= ts_r;
              peak_width     <= WIDTH_W'(1);
              too_long       <= 1'b1;
              state          <= S_WAIT_LOW;
            end else begin
              state <= S_ABOVE;
            end
          end
        end

        S_ABOVE: begin
          if (above) begin
            max_r   <= max_next;
            tmax_r  <= tmax_next;
            width_r <= width_inc;
            if (width_inc == MAXW) begin
              peak_valid     <= 1'b1;
              peak_amplitude <= max_next;
              peak_time      <= tmax_next;
              peak_width     <= width_inc;
              too_long       <= 1'b1;
              state          <= S_WAIT_LOW;
            end
          end else begin
            peak_valid     <= 1'b1;
            peak_amplitude <= max_r;
            peak_time      <= tmax_r;
            peak_width     <= width_r;
            too_long       <= 1'b0;
            if (HOLDOFF == 0) begin
              state <= S_IDLE;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= S_HOLDOFF;
            end
          end
        end

        S_WAIT_LOW: begin
          if (!above) begin
            if (HOLDOFF == 0) begin
              state <= S_IDLE;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= S_HOLDOFF;
            end
          end
        end

        S_HOLDOFF: begin
          // a tail bump restarts the quiet window instead of retriggering
          if (above) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt <= HW'(1)) begin
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
